// File: rtl/spi_slave_if.sv
// SPI responder: synchronizes the SPI pins onto clk, deserializes MOSI
// (LSB first) into framed 32-bit words or out-of-band bytes, and serializes
// response data onto MISO with a valid/ack handshake on both sides.
module spi_slave_if #(
  parameter int          SYNC_STAGES  = 2,
  parameter logic [31:0] TX_IDLE_WORD = 32'h0000_0000,
  parameter logic [7:0]  TX_IDLE_OOB  = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_clk,
  input  logic        spi_mosi,
  input  logic        spi_cs,
  input  logic        spi_frame,
  output logic        spi_miso,
  output logic [31:0] rx_word,
  output logic        rx_word_valid,
  input  logic [31:0] tx_word,
  input  logic        tx_word_valid,
  output logic        tx_word_ack,
  output logic [7:0]  rx_oob,
  output logic        rx_oob_valid,
  input  logic [7:0]  tx_oob,
  input  logic        tx_oob_valid,
  output logic        tx_oob_ack,
  output logic        frame_start,
  output logic        frame_end,
  output logic        frame_err,
  output logic        tx_underrun
);

  typedef enum logic [1:0] {IDLE, ARMED, SHIFT_WORD, SHIFT_OOB} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, cs_sync_q, frm_sync_q;
  logic                   sclk_prev_q, cs_prev_q, frm_prev_q;
  logic                   sclk_s, mosi_s, cs_s, frm_s;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [30:0] rx_sr_q;   // previously received bits, newest at the top
  logic [30:0] tx_sr_q;   // bits still to send after the one on miso_q
  logic        miso_q;
  logic [31:0] rx_word_q;
  logic [7:0]  rx_oob_q;
  logic        rx_word_valid_q, rx_oob_valid_q, tx_word_ack_q, tx_oob_ack_q;
  logic        frame_start_q, frame_end_q, frame_err_q, tx_underrun_q;

  logic        sclk_rise, cs_fall, cs_rise, frm_fall, frm_rise;
  logic        frame_evt, bit_evt, bit_word, last_bit, done;
  logic        ld_word_d, ld_oob_d, ld_valid_d;
  logic [31:0] ld_data_d, rx_word_d;
  logic [7:0]  rx_oob_d;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign frm_s  = frm_sync_q[SYNC_STAGES-1];

  // Input synchronizers plus one delayed copy for edge detection; idle levels
  // are the reset values so no edge is seen when reset is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      frm_sync_q  <= '1;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      frm_prev_q  <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
      frm_sync_q  <= {frm_sync_q[SYNC_STAGES-2:0], spi_frame};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      frm_prev_q  <= frm_s;
    end
  end

  // Edge decode, event priority and TX load selection.
  always_comb begin
    sclk_rise = sclk_s & ~sclk_prev_q;
    cs_fall   = ~cs_s & cs_prev_q;
    cs_rise   = cs_s & ~cs_prev_q;
    frm_fall  = ~frm_s & frm_prev_q;
    frm_rise  = frm_s & ~frm_prev_q;
    // Frame/select edges win over a coincident spi_clk rise.
    frame_evt = ~cs_s & (frm_fall | frm_rise | cs_fall);
    bit_evt   = ~cs_s & ~frame_evt & sclk_rise;
    // Mode is chosen from spi_frame on the first bit of each word/byte.
    bit_word  = (cnt_q == 5'd0) ? ~frm_s : (state_q == SHIFT_WORD);
    last_bit  = bit_word ? (cnt_q == 5'd31) : (cnt_q == 5'd7);
    done      = bit_evt & last_bit;
    ld_word_d = frame_evt ? ~frm_s : (done & bit_word);
    ld_oob_d  = frame_evt ? (cs_fall & frm_s) : (done & ~bit_word);
    ld_valid_d = ld_word_d ? tx_word_valid : tx_oob_valid;
    if (ld_word_d) ld_data_d = tx_word_valid ? tx_word : TX_IDLE_WORD;
    else           ld_data_d = {24'h0, (tx_oob_valid ? tx_oob : TX_IDLE_OOB)};
    rx_word_d = {mosi_s, rx_sr_q};
    rx_oob_d  = {mosi_s, rx_sr_q[30:24]};
  end

  // Transfer FSM with bit counter, shift registers and registered strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      rx_sr_q         <= '0;
      tx_sr_q         <= '0;
      miso_q          <= 1'b0;
      rx_word_q       <= '0;
      rx_oob_q        <= '0;
      rx_word_valid_q <= 1'b0;
      rx_oob_valid_q  <= 1'b0;
      tx_word_ack_q   <= 1'b0;
      tx_oob_ack_q    <= 1'b0;
      frame_start_q   <= 1'b0;
      frame_end_q     <= 1'b0;
      frame_err_q     <= 1'b0;
      tx_underrun_q   <= 1'b0;
    end else begin
      rx_word_valid_q <= 1'b0;
      rx_oob_valid_q  <= 1'b0;
      frame_start_q   <= 1'b0;
      frame_end_q     <= 1'b0;
      frame_err_q     <= 1'b0;
      tx_word_ack_q   <= ld_word_d & tx_word_valid;
      tx_oob_ack_q    <= ld_oob_d & tx_oob_valid;
      tx_underrun_q   <= (ld_word_d | ld_oob_d) & ~ld_valid_d;

      if (cs_rise) begin
        state_q     <= IDLE;
        cnt_q       <= '0;
        miso_q      <= 1'b0;
        frame_err_q <= (cnt_q != 5'd0);
        frame_end_q <= frm_rise;
      end else if (frame_evt) begin
        state_q       <= ARMED;
        cnt_q         <= '0;
        frame_start_q <= frm_fall;
        frame_end_q   <= frm_rise & ~cs_prev_q;
        frame_err_q   <= (frm_fall | frm_rise) & (cnt_q != 5'd0);
      end else if (bit_evt) begin
        rx_sr_q <= {mosi_s, rx_sr_q[30:1]};
        miso_q  <= tx_sr_q[0];
        tx_sr_q <= {1'b0, tx_sr_q[30:1]};
        if (last_bit) begin
          state_q <= ARMED;
          cnt_q   <= '0;
          if (bit_word) begin
            rx_word_q       <= rx_word_d;
            rx_word_valid_q <= 1'b1;
          end else begin
            rx_oob_q       <= rx_oob_d;
            rx_oob_valid_q <= 1'b1;
          end
        end else begin
          state_q <= bit_word ? SHIFT_WORD : SHIFT_OOB;
          cnt_q   <= cnt_q + 5'd1;
        end
      end

      // A load replaces the shift: bit 0 goes straight onto MISO.
      if (ld_word_d | ld_oob_d) begin
        miso_q  <= ld_data_d[0];
        tx_sr_q <= ld_data_d[31:1];
      end
    end
  end

  assign spi_miso      = miso_q & ~cs_s;
  assign rx_word       = rx_word_q;
  assign rx_word_valid = rx_word_valid_q;
  assign tx_word_ack   = tx_word_ack_q;
  assign rx_oob        = rx_oob_q;
  assign rx_oob_valid  = rx_oob_valid_q;
  assign tx_oob_ack    = tx_oob_ack_q;
  assign frame_start   = frame_start_q;
  assign frame_end     = frame_end_q;
  assign frame_err     = frame_err_q;
  assign tx_underrun   = tx_underrun_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Bench for spi_slave_if: bit-banged SPI master, event monitor and a
// transaction-level reference of expected reads, receives and strobe counts.
`timescale 1ns/100ps
module tb_spi_slave_if;

  localparam logic [31:0] IDLE_W = 32'h0000_0000;
  localparam logic [7:0]  IDLE_B = 8'h00;

  logic        clk = 1'b0;
  logic        rst, spi_clk, spi_mosi, spi_cs, spi_frame, spi_miso;
  logic [31:0] rx_word, tx_word;
  logic        rx_word_valid, tx_word_valid, tx_word_ack;
  logic [7:0]  rx_oob, tx_oob;
  logic        rx_oob_valid, tx_oob_valid, tx_oob_ack;
  logic        frame_start, frame_end, frame_err, tx_underrun;

  spi_slave_if #(.SYNC_STAGES(2), .TX_IDLE_WORD(IDLE_W), .TX_IDLE_OOB(IDLE_B)) dut (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_cs(spi_cs),
    .spi_frame(spi_frame), .spi_miso(spi_miso), .rx_word(rx_word),
    .rx_word_valid(rx_word_valid), .tx_word(tx_word), .tx_word_valid(tx_word_valid),
    .tx_word_ack(tx_word_ack), .rx_oob(rx_oob), .rx_oob_valid(rx_oob_valid),
    .tx_oob(tx_oob), .tx_oob_valid(tx_oob_valid), .tx_oob_ack(tx_oob_ack),
    .frame_start(frame_start), .frame_end(frame_end), .frame_err(frame_err),
    .tx_underrun(tx_underrun)
  );

  always #2.5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Event monitor, sampled on the falling clk edge.
  int n_rxw = 0, n_rxb = 0, n_ackw = 0, n_ackb = 0, n_und = 0;
  int n_fs = 0, n_fe = 0, n_err = 0, und_snap = 0;
  logic [31:0] rxw_log [64];
  logic [7:0]  rxb_log [64];

  always @(negedge clk) begin
    if (rx_word_valid) begin
      und_snap = n_und;
      rxw_log[6'(n_rxw)] = rx_word;
      n_rxw++;
    end
    if (rx_oob_valid) begin
      rxb_log[6'(n_rxb)] = rx_oob;
      n_rxb++;
    end
    if (tx_word_ack) n_ackw++;
    if (tx_oob_ack)  n_ackb++;
    if (tx_underrun) n_und++;
    if (frame_start) n_fs++;
    if (frame_end)   n_fe++;
    if (frame_err)   n_err++;
  end

  // Transaction tables: what the master sends, what the device side offers
  // at each load point (entry k feeds word/byte k), and what the master read.
  logic [31:0] m_mosi [8];
  logic [31:0] m_txd  [9];
  bit          m_txv  [9];
  logic [31:0] m_rd   [8];
  logic [7:0]  b_mosi [8];
  logic [7:0]  b_txd  [9];
  bit          b_txv  [9];
  logic [7:0]  b_rd   [8];

  task automatic run_word_frame(input int n);
    logic [31:0] r;
    tx_word = m_txd[0]; tx_word_valid = m_txv[0];
    spi_cs = 1'b0; spi_frame = 1'b0;
    #40;
    for (int w = 0; w < n; w++) begin
      r = '0;
      for (int b = 0; b < 32; b++) begin
        spi_clk = 1'b0; spi_mosi = m_mosi[w][b];
        if (b == 31) begin tx_word = m_txd[w+1]; tx_word_valid = m_txv[w+1]; end
        #20;
        r[b] = spi_miso;
        spi_clk = 1'b1;
        #20;
      end
      m_rd[w] = r;
    end
    spi_clk = 1'b0;
    #40;
    spi_frame = 1'b1; spi_cs = 1'b1;
    #60;
    tx_word_valid = 1'b0;
  endtask

  task automatic run_oob_frame(input int n);
    logic [7:0] r;
    tx_oob = b_txd[0]; tx_oob_valid = b_txv[0];
    spi_cs = 1'b0;
    #40;
    for (int w = 0; w < n; w++) begin
      r = '0;
      for (int b = 0; b < 8; b++) begin
        spi_clk = 1'b0; spi_mosi = b_mosi[w][b];
        if (b == 7) begin tx_oob = b_txd[w+1]; tx_oob_valid = b_txv[w+1]; end
        #20;
        r[b] = spi_miso;
        spi_clk = 1'b1;
        #20;
      end
      b_rd[w] = r;
    end
    spi_clk = 1'b0;
    #40;
    spi_cs = 1'b1;
    #60;
    tx_oob_valid = 1'b0;
  endtask

  // One framed burst of n words; every word completion is also a load point.
  task automatic word_frame_test(input string tag, input int n);
    int rxw0, rxb0, ack0, und0, fs0, fe0, err0, acks, und_mid;
    rxw0 = n_rxw; rxb0 = n_rxb; ack0 = n_ackw; und0 = n_und;
    fs0 = n_fs; fe0 = n_fe; err0 = n_err;
    acks = 0; und_mid = 0;
    for (int k = 0; k <= n; k++) if (m_txv[k]) acks++;
    for (int k = 0; k < n; k++) if (!m_txv[k]) und_mid++;
    run_word_frame(n);
    for (int w = 0; w < n; w++) begin
      check({tag, "_miso_word"}, m_rd[w], m_txv[w] ? m_txd[w] : IDLE_W);
      check({tag, "_rx_word"}, rxw_log[6'(rxw0 + w)], m_mosi[w]);
    end
    check({tag, "_rx_word_cnt"}, n_rxw - rxw0, n);
    check({tag, "_rx_oob_cnt"}, n_rxb - rxb0, 0);
    check({tag, "_ack_cnt"}, n_ackw - ack0, acks);
    check({tag, "_underrun_cnt"}, n_und - und0, n + 1 - acks);
    check({tag, "_underrun_between"}, und_snap - und0, und_mid);
    check({tag, "_frame_start"}, n_fs - fs0, 1);
    check({tag, "_frame_end"}, n_fe - fe0, 1);
    check({tag, "_frame_err"}, n_err - err0, 0);
    check({tag, "_miso_idle"}, {31'h0, spi_miso}, 0);
  endtask

  // cs held low across n OOB bytes with spi_frame high throughout.
  task automatic oob_frame_test(input string tag, input int n);
    int rxw0, rxb0, ack0, und0, fs0, fe0, err0, acks;
    rxw0 = n_rxw; rxb0 = n_rxb; ack0 = n_ackb; und0 = n_und;
    fs0 = n_fs; fe0 = n_fe; err0 = n_err;
    acks = 0;
    for (int k = 0; k <= n; k++) if (b_txv[k]) acks++;
    run_oob_frame(n);
    for (int w = 0; w < n; w++) begin
      check({tag, "_miso_byte"}, {24'h0, b_rd[w]}, {24'h0, (b_txv[w] ? b_txd[w] : IDLE_B)});
      check({tag, "_rx_oob"}, {24'h0, rxb_log[6'(rxb0 + w)]}, {24'h0, b_mosi[w]});
    end
    check({tag, "_rx_oob_cnt"}, n_rxb - rxb0, n);
    check({tag, "_rx_word_cnt"}, n_rxw - rxw0, 0);
    check({tag, "_ack_cnt"}, n_ackb - ack0, acks);
    check({tag, "_underrun_cnt"}, n_und - und0, n + 1 - acks);
    check({tag, "_frame_start"}, n_fs - fs0, 0);
    check({tag, "_frame_end"}, n_fe - fe0, 0);
    check({tag, "_frame_err"}, n_err - err0, 0);
  endtask

  function automatic logic [31:0] strobes();
    return {25'h0, rx_word_valid, rx_oob_valid, tx_word_ack, tx_oob_ack,
            frame_start | frame_end, frame_err, tx_underrun};
  endfunction

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int fs0, fe0, err0, rxw0;
    rst = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0; spi_cs = 1'b1; spi_frame = 1'b1;
    tx_word = '0; tx_word_valid = 1'b0; tx_oob = '0; tx_oob_valid = 1'b0;
    #23.5;
    rst = 1'b0;
    #40;
    check("reset_miso", {31'h0, spi_miso}, 0);
    check("reset_rx_word", rx_word, 0);
    check("reset_rx_oob", {24'h0, rx_oob}, 0);
    check("reset_strobes", strobes(), 0);
    check("reset_events", n_rxw + n_rxb + n_ackw + n_ackb + n_und + n_fs + n_fe + n_err, 0);

    // Single word with a pending response.
    m_mosi[0] = 32'hDEADBEEF; m_txd[0] = 32'h12345678; m_txv[0] = 1'b1;
    m_txd[1] = 32'h0; m_txv[1] = 1'b0;
    word_frame_test("single", 1);

    // Three back-to-back words; only the first response is offered.
    m_mosi[0] = 32'h1; m_mosi[1] = 32'h2; m_mosi[2] = 32'h3;
    m_txd[0] = 32'hA; m_txd[1] = 32'hB; m_txd[2] = 32'hC; m_txd[3] = 32'h0;
    m_txv[0] = 1'b1; m_txv[1] = 1'b0; m_txv[2] = 1'b0; m_txv[3] = 1'b0;
    word_frame_test("burst3", 3);

    // Two OOB bytes under one cs.
    b_mosi[0] = 8'h5A; b_mosi[1] = 8'hC3;
    b_txd[0] = 8'h81; b_txd[1] = 8'h7E; b_txd[2] = 8'h00;
    b_txv[0] = 1'b1; b_txv[1] = 1'b1; b_txv[2] = 1'b0;
    oob_frame_test("oob2", 2);
    check("oob2_last_rx_oob", {24'h0, rx_oob}, 32'hC3);

    // Frame released after 12 bits: partial word dropped.
    fs0 = n_fs; fe0 = n_fe; err0 = n_err; rxw0 = n_rxw;
    tx_word = 32'h55; tx_word_valid = 1'b1;
    spi_cs = 1'b0; spi_frame = 1'b0;
    #40;
    for (int b = 0; b < 12; b++) begin
      spi_clk = 1'b0; spi_mosi = 1'($urandom_range(0, 1));
      #20; spi_clk = 1'b1; #20;
    end
    spi_clk = 1'b0;
    #40;
    spi_frame = 1'b1;
    #60;
    spi_cs = 1'b1;
    #60;
    tx_word_valid = 1'b0;
    check("partial_frame_err", n_err - err0, 1);
    check("partial_frame_end", n_fe - fe0, 1);
    check("partial_frame_start", n_fs - fs0, 1);
    check("partial_rx_word_cnt", n_rxw - rxw0, 0);
    m_mosi[0] = 32'h00000001; m_txd[0] = $urandom; m_txv[0] = 1'b1;
    m_txd[1] = 32'h0; m_txv[1] = 1'b0;
    word_frame_test("after_partial", 1);

    // Randomized word and OOB frames.
    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(1, 3);
      for (int k = 0; k <= n; k++) begin
        m_mosi[k] = $urandom; m_txd[k] = $urandom; m_txv[k] = 1'($urandom_range(0, 1));
      end
      word_frame_test("rand_word", n);
      n = $urandom_range(1, 4);
      for (int k = 0; k <= n; k++) begin
        b_mosi[k] = 8'($urandom); b_txd[k] = 8'($urandom); b_txv[k] = 1'($urandom_range(0, 1));
      end
      oob_frame_test("rand_oob", n);
    end

    // Reset in the middle of a word, then a clean frame.
    tx_word = 32'hFFFF_FFFF; tx_word_valid = 1'b1;
    spi_cs = 1'b0; spi_frame = 1'b0;
    #40;
    for (int b = 0; b < 20; b++) begin
      spi_clk = 1'b0; spi_mosi = 1'b1;
      #20; spi_clk = 1'b1; #20;
    end
    rst = 1'b1;
    #2;
    check("midrst_miso", {31'h0, spi_miso}, 0);
    check("midrst_rx_word", rx_word, 0);
    check("midrst_rx_oob", {24'h0, rx_oob}, 0);
    check("midrst_strobes", strobes(), 0);
    spi_clk = 1'b0; spi_cs = 1'b1; spi_frame = 1'b1; tx_word_valid = 1'b0;
    #28;
    rst = 1'b0;
    #40;
    check("postrst_strobes", strobes(), 0);
    m_mosi[0] = 32'hCAFEF00D; m_txd[0] = $urandom; m_txv[0] = 1'b1;
    m_txd[1] = 32'h0; m_txv[1] = 1'b0;
    word_frame_test("postrst", 1);
    check("postrst_rx_word", rx_word, 32'hCAFEF00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
